alu_seq: RTL and testbench

Parametrised, handshaked successor to the current four-unit ALU top. It accepts one operation at a time over a valid/ready interface and executes add, sub, logic, compare and shift in a single cycle. Multiply and divide run iteratively, one bit per cycle. The result is held in one output register until the consumer accepts it. It sits between the register-file read stage and the write-back stage.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_seq_iter.sv | 102 ++++++++++
 rtl/alu_seq.sv | 203 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked sequential ALU: opcode groups, op codes,
// compare result codes, FSM state type and iteration counter sizing.
package alu_pkg;

    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_CMP   = 2'b10;
    localparam logic [1:0] GRP_SHIFT = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    localparam logic [1:0] OP_EQ   = 2'b00;
    localparam logic [1:0] OP_GT   = 2'b01;
    localparam logic [1:0] OP_LT   = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    localparam logic [1:0] OP_SHR_A = 2'b00;
    localparam logic [1:0] OP_SHL_A = 2'b01;
    localparam logic [1:0] OP_SHR_B = 2'b10;
    localparam logic [1:0] OP_SHL_B = 2'b11;

    localparam logic [1:0] CMP_RES_EQ = 2'd1;
    localparam logic [1:0] CMP_RES_GT = 2'd2;
    localparam logic [1:0] CMP_RES_LT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative MUL/DIV datapath: one shift-add or restoring-subtract step per cycle.
// The divide path exists only when ALU_DIV_EN is defined.
module alu_seq_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef ALU_DIV_EN
    input  logic                 div_sel,
`endif
    input  logic                 start,
    input  logic                 step,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     opnd_r;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [2*WIDTH-1:0]   step_next_s;

    // Multiply step: upper half accumulates, lower half shifts the multiplier out LSB first.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                   + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end

`ifdef ALU_DIV_EN
    logic               div_r;
    logic [WIDTH:0]     div_part_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] div_next_s;

    // Restoring divide step: {rem, quo} shifts left, keep the difference when it does not borrow.
    always_comb begin
        div_part_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s = div_part_s - {1'b0, opnd_r};
        if (!div_diff_s[WIDTH]) begin
            div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {div_part_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
        step_next_s = div_r ? div_next_s : mul_next_s;
    end

    // Remembers which operation the current run performs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_r <= 1'b0;
        end else if (start) begin
            div_r <= div_sel;
        end else begin
            div_r <= div_r;
        end
    end
`else
    // Only multiply is iterative in this build.
    always_comb begin
        step_next_s = mul_next_s;
    end
`endif

    // Operand load on start, one datapath step per enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            acc_r  <= {(2*WIDTH){1'b0}};
            opnd_r <= {WIDTH{1'b0}};
        end else if (start) begin
            cnt_r  <= {CW{1'b0}};
`ifdef ALU_DIV_EN
            acc_r  <= div_sel ? {{WIDTH{1'b0}}, op_a} : {{WIDTH{1'b0}}, op_b};
            opnd_r <= div_sel ? op_b : op_a;
`else
            acc_r  <= {{WIDTH{1'b0}}, op_b};
            opnd_r <= op_a;
`endif
        end else if (step) begin
            cnt_r  <= cnt_r + CW'(1);
            acc_r  <= step_next_s;
            opnd_r <= opnd_r;
        end else begin
            cnt_r  <= cnt_r;
            acc_r  <= acc_r;
            opnd_r <= opnd_r;
        end
    end

    assign last   = (cnt_r == CNT_LAST);
    assign result = acc_r;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU top: FSM, single-cycle ops, output register and valid/ready handshake.
// Optional macro ALU_DIV_EN enables the iterative divider.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           ALU_FUN,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [2*WIDTH-1:0]   ALU_OUT,
    output logic                 CARRY,
    output logic                 ZERO,
    output logic                 ERR,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY
);

    state_e               state_r;
    state_e               next_state_s;
    logic                 in_ready_s;
    logic                 start_s;
    logic                 step_s;
    logic                 load_single_s;
    logic                 load_iter_s;
    logic                 is_mul_s;
    logic                 is_div_s;
    logic                 multi_s;
    logic                 iter_last_s;
    logic [2*WIDTH-1:0]   iter_res_s;
    logic [1:0]           grp_s;
    logic [1:0]           op_s;
    logic [WIDTH:0]       add_s;
    logic [2*WIDTH-1:0]   res_s;
    logic                 carry_s;
    logic                 err_s;

    assign grp_s    = ALU_FUN[3:2];
    assign op_s     = ALU_FUN[1:0];
    assign is_mul_s = (grp_s == GRP_ARITH) && (op_s == OP_MUL);
    assign is_div_s = (grp_s == GRP_ARITH) && (op_s == OP_DIV);
`ifdef ALU_DIV_EN
    assign multi_s  = is_mul_s || (is_div_s && (B != {WIDTH{1'b0}}));
`else
    assign multi_s  = is_mul_s;
`endif
    assign IN_READY = in_ready_s;

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (CLK),
        .rst_n   (RST),
`ifdef ALU_DIV_EN
        .div_sel (is_div_s),
`endif
        .start   (start_s),
        .step    (step_s),
        .op_a    (A),
        .op_b    (B),
        .last    (iter_last_s),
        .result  (iter_res_s)
    );

    // Single-cycle result; DIV lands here only for B=0 or when the divider is absent.
    always_comb begin
        add_s   = {1'b0, A} + {1'b0, B};
        res_s   = {(2*WIDTH){1'b0}};
        carry_s = 1'b0;
        err_s   = 1'b0;
        case (grp_s)
            GRP_ARITH: begin
                case (op_s)
                    OP_ADD: begin
                        res_s   = {{(WIDTH-1){1'b0}}, add_s};
                        carry_s = add_s[WIDTH];
                    end
                    OP_SUB: begin
                        res_s   = {{WIDTH{1'b0}}, A - B};
                        carry_s = (A < B);
                    end
                    OP_DIV: begin
`ifdef ALU_DIV_EN
                        res_s = {A, {WIDTH{1'b1}}};
`else
                        res_s = {(2*WIDTH){1'b0}};
`endif
                        err_s = 1'b1;
                    end
                    default: res_s = {(2*WIDTH){1'b0}};
                endcase
            end
            GRP_LOGIC: begin
                case (op_s)
                    OP_AND:  res_s = {{WIDTH{1'b0}}, A & B};
                    OP_OR:   res_s = {{WIDTH{1'b0}}, A | B};
                    OP_NAND: res_s = {{WIDTH{1'b0}}, ~(A & B)};
                    OP_NOR:  res_s = {{WIDTH{1'b0}}, ~(A | B)};
                    default: res_s = {(2*WIDTH){1'b0}};
                endcase
            end
            GRP_CMP: begin
                case (op_s)
                    OP_EQ:   res_s = (A == B) ? {{(2*WIDTH-2){1'b0}}, CMP_RES_EQ} : {(2*WIDTH){1'b0}};
                    OP_GT:   res_s = (A > B)  ? {{(2*WIDTH-2){1'b0}}, CMP_RES_GT} : {(2*WIDTH){1'b0}};
                    OP_LT:   res_s = (A < B)  ? {{(2*WIDTH-2){1'b0}}, CMP_RES_LT} : {(2*WIDTH){1'b0}};
                    default: res_s = {(2*WIDTH){1'b0}};
                endcase
            end
            GRP_SHIFT: begin
                case (op_s)
                    OP_SHR_A: res_s = {{WIDTH{1'b0}}, 1'b0, A[WIDTH-1:1]};
                    OP_SHL_A: res_s = {{WIDTH{1'b0}}, A[WIDTH-2:0], 1'b0};
                    OP_SHR_B: res_s = {{WIDTH{1'b0}}, 1'b0, B[WIDTH-1:1]};
                    OP_SHL_B: res_s = {{WIDTH{1'b0}}, B[WIDTH-2:0], 1'b0};
                    default:  res_s = {(2*WIDTH){1'b0}};
                endcase
            end
            default: res_s = {(2*WIDTH){1'b0}};
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state, handshake ready and load/start/step strobes.
    always_comb begin
        next_state_s  = state_r;
        in_ready_s    = 1'b0;
        start_s       = 1'b0;
        step_s        = 1'b0;
        load_single_s = 1'b0;
        load_iter_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = !OUT_VALID || OUT_READY;
                if (IN_VALID && in_ready_s) begin
                    if (multi_s) begin
                        start_s      = 1'b1;
                        next_state_s = ST_BUSY;
                    end else begin
                        load_single_s = 1'b1;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                step_s = 1'b1;
                if (iter_last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (!OUT_VALID || OUT_READY) begin
                    load_iter_s  = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output register: a new load wins over a consume, so OUT_VALID stays up on replace.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ALU_OUT   <= {(2*WIDTH){1'b0}};
            CARRY     <= 1'b0;
            ZERO      <= 1'b0;
            ERR       <= 1'b0;
            OUT_VALID <= 1'b0;
        end else if (load_single_s) begin
            ALU_OUT   <= res_s;
            CARRY     <= carry_s;
            ZERO      <= (res_s == {(2*WIDTH){1'b0}});
            ERR       <= err_s;
            OUT_VALID <= 1'b1;
        end else if (load_iter_s) begin
            ALU_OUT   <= iter_res_s;
            CARRY     <= 1'b0;
            ZERO      <= (iter_res_s == {(2*WIDTH){1'b0}});
            ERR       <= 1'b0;
            OUT_VALID <= 1'b1;
        end else if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= OUT_VALID;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8; divide expectations follow ALU_DIV_EN.
module tb_alu_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  ALU_FUN;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] ALU_OUT;
    logic        CARRY;
    logic        ZERO;
    logic        ERR;
    logic        OUT_VALID;
    logic        OUT_READY;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .B         (B),
        .ALU_FUN   (ALU_FUN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .ALU_OUT   (ALU_OUT),
        .CARRY     (CARRY),
        .ZERO      (ZERO),
        .ERR       (ERR),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one request for a single edge, then drop IN_VALID.
    task automatic issue(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b);
        ALU_FUN  = fun;
        A        = a;
        B        = b;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        A = 8'h00; B = 8'h00; ALU_FUN = 4'h0;
        tick(); tick();
        RST = 1'b1;
        checks++;
        if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
        checks++;
        if ({ALU_OUT, CARRY, ZERO, ERR} !== 19'h0) begin errors++; $display("FAIL reset_outputs got %h %b%b%b want 0", ALU_OUT, CARRY, ZERO, ERR); end
        checks++;
        if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", IN_READY); end
    endtask

    task automatic test_add();
        OUT_READY = 1'b1;
        issue(4'b0000, 8'hFF, 8'h01);
        checks++;
        if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL add_latency got %b want 1", OUT_VALID); end
        checks++;
        if ({ALU_OUT, CARRY, ZERO, ERR} !== {16'h0100, 3'b100}) begin errors++; $display("FAIL add_result got %h c%b z%b e%b want 0100 c1 z0 e0", ALU_OUT, CARRY, ZERO, ERR); end
        tick();
        checks++;
        if (OUT_VALID !== 1'b0 || ALU_OUT !== 16'h0100 || CARRY !== 1'b1) begin errors++; $display("FAIL consume_hold got v%b %h c%b want v0 0100 c1", OUT_VALID, ALU_OUT, CARRY); end
    endtask

    // One single-cycle op per clock with OUT_READY held high.
    task automatic test_back_to_back();
        logic [3:0]  fun_t [0:11];
        logic [7:0]  a_t   [0:11];
        logic [7:0]  b_t   [0:11];
        logic [15:0] exp_t [0:11];
        logic        cz_t  [0:11][0:1];
        fun_t[0]  = 4'b0101; a_t[0]  = 8'h0F; b_t[0]  = 8'hF0; exp_t[0]  = 16'h00FF; // OR
        fun_t[1]  = 4'b0110; a_t[1]  = 8'hFF; b_t[1]  = 8'hFF; exp_t[1]  = 16'h0000; // NAND
        fun_t[2]  = 4'b0111; a_t[2]  = 8'h01; b_t[2]  = 8'h02; exp_t[2]  = 16'h00FC; // NOR
        fun_t[3]  = 4'b1001; a_t[3]  = 8'h09; b_t[3]  = 8'h03; exp_t[3]  = 16'h0002; // GT
        fun_t[4]  = 4'b1010; a_t[4]  = 8'h09; b_t[4]  = 8'h03; exp_t[4]  = 16'h0000; // LT false
        fun_t[5]  = 4'b1010; a_t[5]  = 8'h03; b_t[5]  = 8'h09; exp_t[5]  = 16'h0003; // LT true
        fun_t[6]  = 4'b1011; a_t[6]  = 8'h05; b_t[6]  = 8'h05; exp_t[6]  = 16'h0000; // cmp none
        fun_t[7]  = 4'b1100; a_t[7]  = 8'h81; b_t[7]  = 8'h00; exp_t[7]  = 16'h0040; // A>>1
        fun_t[8]  = 4'b1101; a_t[8]  = 8'h81; b_t[8]  = 8'h00; exp_t[8]  = 16'h0002; // A<<1
        fun_t[9]  = 4'b1110; a_t[9]  = 8'h00; b_t[9]  = 8'h81; exp_t[9]  = 16'h0040; // B>>1
        fun_t[10] = 4'b1111; a_t[10] = 8'h00; b_t[10] = 8'h40; exp_t[10] = 16'h0080; // B<<1
        fun_t[11] = 4'b0001; a_t[11] = 8'h03; b_t[11] = 8'h05; exp_t[11] = 16'h00FE; // SUB borrow
        for (int i = 0; i < 12; i++) begin
            cz_t[i][0] = (i == 11);
            cz_t[i][1] = (exp_t[i] == 16'h0000);
        end
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ALU_FUN = fun_t[i]; A = a_t[i]; B = b_t[i];
            tick();
            checks++;
            if (OUT_VALID !== 1'b1 || ALU_OUT !== exp_t[i] || CARRY !== cz_t[i][0] || ZERO !== cz_t[i][1]) begin
                errors++;
                $display("FAIL b2b_%0d got v%b %h c%b z%b want v1 %h c%b z%b", i, OUT_VALID, ALU_OUT, CARRY, ZERO, exp_t[i], cz_t[i][0], cz_t[i][1]);
            end
        end
        IN_VALID = 1'b0;
        tick();
    endtask

    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] expv, input string name);
        int bad;
        bad = 0;
        OUT_READY = 1'b1;
        issue(4'b0010, a, b);
        for (int k = 0; k < 9; k++) begin
            if (OUT_VALID !== 1'b0 || IN_READY !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL %s_busy got %0d bad cycles want 0", name, bad); end
        checks++;
        if (OUT_VALID !== 1'b1 || ALU_OUT !== expv || ERR !== 1'b0 || CARRY !== 1'b0) begin
            errors++; $display("FAIL %s_result got v%b %h e%b want v1 %h e0", name, OUT_VALID, ALU_OUT, ERR, expv);
        end
        tick();
    endtask

    task automatic test_mul();
        run_mul(8'hFF, 8'hFF, 16'hFE01, "mul_ff");
        run_mul(8'd12, 8'd11, 16'h0084, "mul_12x11");
    endtask

    task automatic test_div();
        OUT_READY = 1'b1;
`ifdef ALU_DIV_EN
        begin
            int bad;
            bad = 0;
            issue(4'b0011, 8'd200, 8'd7);
            for (int k = 0; k < 9; k++) begin
                if (OUT_VALID !== 1'b0) bad++;
                tick();
            end
            checks++;
            if (bad != 0 || OUT_VALID !== 1'b1 || ALU_OUT !== 16'h041C || ERR !== 1'b0) begin
                errors++; $display("FAIL div_200_7 got v%b %h e%b bad%0d want v1 041c e0", OUT_VALID, ALU_OUT, ERR, bad);
            end
            tick();
        end
        issue(4'b0011, 8'h2A, 8'h00);
        checks++;
        if (OUT_VALID !== 1'b1 || ALU_OUT !== 16'h2AFF || ERR !== 1'b1) begin
            errors++; $display("FAIL div_by_zero got v%b %h e%b want v1 2aff e1", OUT_VALID, ALU_OUT, ERR);
        end
`else
        issue(4'b0011, 8'd200, 8'd7);
        checks++;
        if (OUT_VALID !== 1'b1 || ALU_OUT !== 16'h0000 || ERR !== 1'b1 || ZERO !== 1'b1) begin
            errors++; $display("FAIL div_disabled got v%b %h e%b z%b want v1 0000 e1 z1", OUT_VALID, ALU_OUT, ERR, ZERO);
        end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        OUT_READY = 1'b0;
        issue(4'b0001, 8'd5, 8'd3);
        checks++;
        if (OUT_VALID !== 1'b1 || ALU_OUT !== 16'h0002 || CARRY !== 1'b0 || IN_READY !== 1'b0) begin
            errors++; $display("FAIL bp_sub got v%b %h c%b r%b want v1 0002 c0 r0", OUT_VALID, ALU_OUT, CARRY, IN_READY);
        end
        ALU_FUN = 4'b0100; A = 8'hF0; B = 8'h3C; IN_VALID = 1'b1;
        tick(); tick();
        checks++;
        if (OUT_VALID !== 1'b1 || ALU_OUT !== 16'h0002 || IN_READY !== 1'b0) begin
            errors++; $display("FAIL bp_hold got v%b %h r%b want v1 0002 r0", OUT_VALID, ALU_OUT, IN_READY);
        end
        OUT_READY = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin errors++; $display("FAIL bp_ready got %b want 1", IN_READY); end
        tick();
        OUT_READY = 1'b0; IN_VALID = 1'b0;
        checks++;
        if (OUT_VALID !== 1'b1 || ALU_OUT !== 16'h0030 || ZERO !== 1'b0) begin
            errors++; $display("FAIL bp_replace got v%b %h z%b want v1 0030 z0", OUT_VALID, ALU_OUT, ZERO);
        end
        OUT_READY = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_mul();
        int bad;
        bad = 0;
        OUT_READY = 1'b1;
        issue(4'b0000, 8'hFF, 8'h01);
        issue(4'b0010, 8'hFF, 8'hFF);
        tick(); tick(); tick();
        RST = 1'b0;
        tick();
        RST = 1'b1;
        checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || {ALU_OUT, CARRY, ZERO, ERR} !== 19'h0) begin
            errors++; $display("FAIL rst_mid_mul got v%b r%b %h c%b z%b e%b want v0 r1 0000 000", OUT_VALID, IN_READY, ALU_OUT, CARRY, ZERO, ERR);
        end
        for (int k = 0; k < 10; k++) begin
            if (OUT_VALID !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rst_discard got %0d valid cycles want 0", bad); end
        issue(4'b1000, 8'd7, 8'd7);
        checks++;
        if (OUT_VALID !== 1'b1 || ALU_OUT !== 16'h0001) begin
            errors++; $display("FAIL eq_after_rst got v%b %h want v1 0001", OUT_VALID, ALU_OUT);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
